// File: rtl/r3_sdf_stage_ctrl_if.sv
// Sample-side handshake and delay-line/butterfly control bundle for one
// radix-3 SDF stage controller.
interface r3_sdf_stage_ctrl_if #(
    parameter int TW_AW = 5
);
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic             dl_en;
    logic [1:0]       phase;
    logic             bf_en;
    logic [TW_AW-1:0] tw_idx;
    logic             out_valid;
    logic             frame_done;
    logic             err;

    modport master (
        output in_valid, in_last,
        input  in_ready, dl_en, phase, bf_en, tw_idx, out_valid, frame_done, err
    );

    modport slave (
        input  in_valid, in_last,
        output in_ready, dl_en, phase, bf_en, tw_idx, out_valid, frame_done, err
    );
endinterface

// File: rtl/r3_sdf_stage_ctrl.sv
// Sequencing controller for a radix-3 single-path delay-feedback FFT stage:
// counts samples, selects fill/butterfly/emit phase, twiddle index and drain.
module r3_sdf_stage_ctrl #(
    parameter int DEPTH = 9,
    parameter int CW    = 4,
    parameter int TW_AW = 5
) (
    input logic                clk,
    input logic                rst_n,
    r3_sdf_stage_ctrl_if.slave bus
);
    typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} mode_t;

    mode_t            mode_q, mode_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic [1:0]       ph_q, ph_n;
    logic             primed_q, primed_n;
    logic             ready_p1;

    logic             vld_p1, dl_p1, bf_p1, fd_p1, err_p1;
    logic [1:0]       phase_p1;
    logic [TW_AW-1:0] tw_p1;
    logic             vld_n, dl_n, bf_n, fd_n, err_n;
    logic [1:0]       phase_n;
    logic [TW_AW-1:0] tw_n;

    logic accept, advance, cnt_last, misalign;

    // Emitted branch is X1 in ph 0, X2 in ph 1, X0 in ph 2; exponent = branch*cnt.
    function automatic logic [TW_AW-1:0] tw_of(input logic [1:0] p, input logic [CW-1:0] c);
        logic [TW_AW-1:0] ce;
        ce = TW_AW'(c);
        case (p)
            2'd0:    tw_of = ce;
            2'd1:    tw_of = ce << 1;
            default: tw_of = '0;
        endcase
    endfunction

    assign accept   = (mode_q == RUN) && bus.in_valid && ready_p1;
    assign advance  = accept || (mode_q == DRAIN);
    assign cnt_last = (cnt_q == CW'(DEPTH - 1));
    assign misalign = accept && bus.in_last && !((ph_q == 2'd2) && cnt_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= RUN;
            cnt_q    <= '0;
            ph_q     <= 2'd0;
            primed_q <= 1'b0;
            ready_p1 <= 1'b0;
            vld_p1   <= 1'b0;
            dl_p1    <= 1'b0;
            bf_p1    <= 1'b0;
            fd_p1    <= 1'b0;
            err_p1   <= 1'b0;
            phase_p1 <= 2'd0;
            tw_p1    <= '0;
        end else begin
            mode_q   <= mode_n;
            cnt_q    <= cnt_n;
            ph_q     <= ph_n;
            primed_q <= primed_n;
            ready_p1 <= (mode_n == RUN);
            vld_p1   <= vld_n;
            dl_p1    <= dl_n;
            bf_p1    <= bf_n;
            fd_p1    <= fd_n;
            err_p1   <= err_n;
            phase_p1 <= phase_n;
            tw_p1    <= tw_n;
        end
    end

    always_comb begin
        mode_n   = mode_q;
        cnt_n    = cnt_q;
        ph_n     = ph_q;
        primed_n = primed_q;
        if (misalign) begin
            cnt_n    = '0;
            ph_n     = 2'd0;
            primed_n = 1'b0;
        end else if (advance) begin
            cnt_n = cnt_last ? '0 : cnt_q + CW'(1);
            if (cnt_last) ph_n = (ph_q == 2'd2) ? 2'd0 : ph_q + 2'd1;
            if (ph_q == 2'd2) primed_n = 1'b1;
            if (accept && bus.in_last) mode_n = DRAIN;
            // Final X2 of the drain: back to an empty, unprimed RUN state.
            if ((mode_q == DRAIN) && (ph_q == 2'd1) && cnt_last) begin
                mode_n   = RUN;
                ph_n     = 2'd0;
                primed_n = 1'b0;
            end
        end
    end

    always_comb begin
        vld_n   = 1'b0;
        dl_n    = 1'b0;
        bf_n    = 1'b0;
        fd_n    = 1'b0;
        err_n   = misalign;
        phase_n = phase_p1;
        tw_n    = tw_p1;
        if (advance && !misalign) begin
            dl_n    = 1'b1;
            phase_n = ph_q;
            bf_n    = (ph_q == 2'd2);
            tw_n    = tw_of(ph_q, cnt_q);
            vld_n   = (ph_q == 2'd2) || primed_q;
            fd_n    = (ph_q == 2'd1) && cnt_last && primed_q;
        end
    end

    // Stage p1 boundary: registered view of the last advanced sample.
    assign bus.in_ready   = ready_p1;
    assign bus.dl_en      = dl_p1;
    assign bus.phase      = phase_p1;
    assign bus.bf_en      = bf_p1;
    assign bus.tw_idx     = tw_p1;
    assign bus.out_valid  = vld_p1;
    assign bus.frame_done = fd_p1;
    assign bus.err        = err_p1;
endmodule

// File: tb/tb_r3_sdf_stage_ctrl.sv
// Scoreboard bench for r3_sdf_stage_ctrl: stimulus queues expected emitted
// samples, a negedge monitor pops and compares on every out_valid.
module tb_r3_sdf_stage_ctrl;
    localparam int D = 9;
    localparam int N = 3 * D;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    r3_sdf_stage_ctrl_if #(.TW_AW(5)) bus ();

    r3_sdf_stage_ctrl #(.DEPTH(D), .CW(4), .TW_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct packed {
        logic [1:0] ph;
        logic [4:0] tw;
        logic       bf;
        logic       fd;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   pos = 0;
    bit   primed = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input int ph, input int c, input bit pr);
        exp_t e;
        e.ph = 2'(ph);
        e.tw = (ph == 0) ? 5'(c) : (ph == 1) ? 5'(2 * c) : 5'd0;
        e.bf = (ph == 2);
        e.fd = (ph == 1) && (c == D - 1) && pr;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (bus.out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out_valid", int'(bus.out_valid), 0);
            end else begin
                e = q.pop_front();
                chk("out_phase", int'(bus.phase), int'(e.ph));
                chk("out_tw_idx", int'(bus.tw_idx), int'(e.tw));
                chk("out_bf_en", int'(bus.bf_en), int'(e.bf));
                chk("out_frame_done", int'(bus.frame_done), int'(e.fd));
            end
        end else if (bus.frame_done) begin
            chk("frame_done_without_out_valid", int'(bus.frame_done), 0);
        end
    end

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    // Present one sample; the outputs describing it are visible on return.
    task automatic send(input bit last);
        int ph, c, w;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            idle();
            w++;
        end
        if (w >= 50) chk("in_ready_timeout", int'(bus.in_ready), 1);
        ph = pos / D;
        c  = pos % D;
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        if (last && !(ph == 2 && c == D - 1)) begin
            pos    = 0;
            primed = 1'b0;
        end else begin
            if (ph == 2 || primed) q.push_back(mk(ph, c, primed));
            if (ph == 2) primed = 1'b1;
            pos = (pos + 1) % N;
            if (last) begin
                for (int k = 0; k < 2 * D; k++) q.push_back(mk(k / D, k % D, 1'b1));
                pos    = 0;
                primed = 1'b0;
            end
        end
        idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic first_frame(input string tag);
        for (int i = 0; i < N; i++) begin
            send(1'b0);
            if (i == 2 * D - 1) chk({tag, "_ov_before_prime"}, int'(bus.out_valid), 0);
            if (i == 2 * D) begin
                chk({tag, "_ov_first"}, int'(bus.out_valid), 1);
                chk({tag, "_bf_first"}, int'(bus.bf_en), 1);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, lows;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        #12;
        chk("reset_outputs", int'({bus.in_ready, bus.dl_en, bus.phase, bus.bf_en, bus.tw_idx,
                                   bus.out_valid, bus.frame_done, bus.err}), 0);
        rst_n = 1'b1;
        idle();
        idle();
        chk("ready_after_reset", int'(bus.in_ready), 1);

        // Scenario 1 and 2: two gap-free frames.
        first_frame("s1");
        bad = 0;
        for (int i = 0; i < N; i++) begin
            send(1'b0);
            if (!bus.out_valid) bad++;
        end
        chk("s2_ov_continuous_gaps", bad, 0);

        // Scenario 3: frame closed with an aligned in_last, then drain.
        for (int i = 0; i < N; i++) send(i == N - 1);
        lows = 0;
        while (!bus.in_ready && lows < 40) begin
            lows++;
            idle();
        end
        chk("s3_drain_ready_low_cycles", lows, 2 * D);
        send(1'b0);
        chk("s3_phase_after_drain", int'(bus.phase), 0);
        chk("s3_unprimed_after_drain", int'(bus.out_valid), 0);
        chk("s3_dl_en", int'(bus.dl_en), 1);

        // Scenario 4: gapped stream.
        bad = 0;
        for (int i = 0; i < 35; i++) begin
            send(1'b0);
            idle();
            if (bus.out_valid || bus.dl_en) bad++;
        end
        chk("s4_gap_cycles_quiet", bad, 0);

        // Scenario 5: misaligned in_last at ph 1, cnt 4.
        for (int i = 0; i < 4; i++) send(1'b0);
        send(1'b1);
        chk("s5_err_pulse", int'(bus.err), 1);
        chk("s5_no_out_valid", int'(bus.out_valid), 0);
        chk("s5_no_dl_en", int'(bus.dl_en), 0);
        send(1'b0);
        chk("s5_err_cleared", int'(bus.err), 0);
        chk("s5_next_phase", int'(bus.phase), 0);
        chk("s5_next_tw", int'(bus.tw_idx), 0);
        chk("s5_next_ov", int'(bus.out_valid), 0);

        // Scenario 6: async reset at ph 2, cnt 5, then a fresh frame.
        for (int i = 0; i < 22; i++) send(1'b0);
        idle();
        rst_n = 1'b0;
        #1;
        chk("s6_reset_outputs", int'({bus.in_ready, bus.dl_en, bus.phase, bus.bf_en, bus.tw_idx,
                                      bus.out_valid, bus.frame_done, bus.err}), 0);
        idle();
        rst_n  = 1'b1;
        pos    = 0;
        primed = 1'b0;
        first_frame("s6");

        for (int i = 0; i < 5; i++) idle();
        chk("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
